wb_regfile: RTL

- Write-back end of the execute-stage result interface.
- Accepts the EX result triple (wd_i, wreg_i, wdata_i) and holds it for one cycle in a write-back staging register.
- Commits the staged result into a 32 x 32-bit general register file.
- Provides two read ports to decode, with EX-stage and WB-stage bypass so that back-to-back dependent instructions read correct operands.

---
 rtl/wb_regfile.sv | 106 ++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back staging register plus a 32 x 32-bit general register
// file with two combinational read ports for decode.
// Optional feature macro: WB_REGFILE_BYPASS_EN enables EX-stage and WB-stage
// operand bypass on both read ports. Without it, reads return array contents
// only and the hazard unit must stall two cycles on a RAW dependency.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o
);

  // Write-back staging register (EX result delayed by one cycle)
  logic [ADDR_W-1:0] wd_p1;
  logic              wreg_p1;
  logic [DATA_W-1:0] wdata_p1;

  // Architectural register array; entry 0 is never written
  logic [DATA_W-1:0] regs [NUM_REGS];

  // A staged result commits only on a non-stalled edge, so a result held
  // through a stall is written exactly once, on the edge that releases it.
  logic commit;
  assign commit = !stall_i && wreg_p1 && (wd_p1 != '0);

  // ---- EX -> WB stage boundary ----
  // Capture the EX result triple unless stalled; reset discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_p1    <= '0;
      wreg_p1  <= 1'b0;
      wdata_p1 <= '0;
    end else if (!stall_i) begin
      wd_p1    <= wd_i;
      wreg_p1  <= wreg_i;
      wdata_p1 <= wdata_i;
    end
  end

  // ---- WB -> register file boundary ----
  // Commit the staged result into the array; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wd_p1] <= wdata_p1;
    end
  end

  assign wb_wd_o   = wd_p1;
  assign wb_wreg_o = wreg_p1;

  // Read port 1: disabled/zero-address/reset give 0, then youngest bypass
  // source wins over the staged result, which wins over the array.
  always_comb begin
    rdata1_o = '0;
    if (!rst && re1_i && (raddr1_i != '0)) begin
`ifdef WB_REGFILE_BYPASS_EN
      if (wreg_i && (wd_i == raddr1_i)) begin
        rdata1_o = wdata_i;
      end else if (wreg_p1 && (wd_p1 == raddr1_i)) begin
        rdata1_o = wdata_p1;
      end else begin
        rdata1_o = regs[raddr1_i];
      end
`else
      rdata1_o = regs[raddr1_i];
`endif
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rdata2_o = '0;
    if (!rst && re2_i && (raddr2_i != '0)) begin
`ifdef WB_REGFILE_BYPASS_EN
      if (wreg_i && (wd_i == raddr2_i)) begin
        rdata2_o = wdata_i;
      end else if (wreg_p1 && (wd_p1 == raddr2_i)) begin
        rdata2_o = wdata_p1;
      end else begin
        rdata2_o = regs[raddr2_i];
      end
`else
      rdata2_o = regs[raddr2_i];
`endif
    end
  end

endmodule
